recibirps2: RTL and testbench
=============================

Name: recibirps2

Overview:
PS/2 device-to-host receiver, the return path paired with the team's host-to-device transmitter (transmitirps2).
- Samples the open-collector PS/2 clock and data lines.
- Deframes 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
- Presents each received byte with a one-cycle done strobe and error flags to the keyboard scan-code logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of ps2_clk and ps2_data (minimum 2).
FILTER_LEN, 4, consecutive equal synchronized ps2_clk samples required before the filtered clock changes.
TIMEOUT_CYC, 5000, CLKOUT cycles without a falling edge mid-frame before the frame is aborted (100 us at 50 MHz).

Ports:
CLKOUT  in  1  system clock; all state on its rising edge
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock line (asynchronous)
ps2_data  in  1  raw PS/2 data line (asynchronous)
rx_en  in  1  1 = accept new frames; gates start-bit detection only
d_out  out  8  last received byte
rx_done  out  1  one-cycle pulse, frame complete
parity_err  out  1  parity of last frame bad; valid from rx_done, held until next rx_done
frame_err  out  1  stop bit of last frame was 0; valid from rx_done, held until next rx_done
busy  out  1  state != IDLE
rx_timeout  out  1  one-cycle pulse, frame aborted by watchdog

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; shift register and bit_cnt = 0.
  - d_out = 8'h00; rx_done, parity_err, frame_err, busy, rx_timeout = 0.
  - Synchronizers and filter are set to 1 (idle line level).
- Input conditioning:
  - Both lines pass through SYNC_STAGES flip-flops.
  - Filtered clock clk_f changes only after FILTER_LEN consecutive equal samples.
  - strobe = 1 for one cycle on the clk_f 1->0 transition.
  - Data is sampled from the synchronized ps2_data in the strobe cycle.
- FSM (advances only on strobe):
  - IDLE:
    - data=0 and rx_en=1 -> DATA, bit_cnt=0.
    - data=1, or rx_en=0 -> stay in IDLE; the bit is ignored.
  - DATA: shift right, new bit into MSB; bit_cnt+1. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP, in the same clock edge:
    - d_out <= shift register.
    - parity_err <= ~(^{data8, parity}).
    - frame_err <= ~stop_bit.
    - rx_done = 1 in the next cycle only.
    - Next state IDLE.
    - d_out and rx_done update even on error.
- Latency: rx_done is high exactly one cycle after the stop-bit strobe cycle. The strobe itself trails the ps2_clk falling pin edge by SYNC_STAGES+FILTER_LEN cycles.
- rx_en falling mid-frame: the current frame completes normally.
- Back-to-back frames: the first strobe after STOP is evaluated in IDLE; no dead cycles are required.
- Reset mid-frame: immediate return to IDLE with no rx_done. Remaining line bits are treated as new traffic.
- Glitch on ps2_clk shorter than FILTER_LEN cycles: no strobe, no state change.

Optional Feature:
PS2_RX_TIMEOUT_EN:
- Defined:
  - A counter clears on every strobe and on entry to IDLE, and counts while busy.
  - On reaching TIMEOUT_CYC-1: state -> IDLE, rx_timeout pulses one cycle, no rx_done.
  - d_out and the error flags are unchanged.
- Undefined:
  - No counter is present; rx_timeout is tied 0.
  - A truncated frame waits indefinitely for further clock edges.

Test Plan:
Bench settings for all scenarios: CLKOUT period 2 ns; PS/2 half-period 40 CLKOUT cycles; ps2_data changes mid-high phase.
1. Reset sequence: rst_n low 4 cycles then high, frame 0x1C with parity 0 and stop 1 -> rx_done one pulse; d_out=8'h1C, parity_err=0, frame_err=0, busy low afterwards.
2. Back-to-back frames 0xF0 (parity 1) then 0xAA (parity 1) -> two rx_done pulses; d_out=8'hF0 then 8'hAA, no errors.
3. Frame 0x1C with parity bit 1 -> rx_done pulse; d_out=8'h1C, parity_err=1. Next good frame 0x1C clears parity_err to 0.
4. Frame 0x55 (parity 1) with stop bit 0 -> frame_err=1, parity_err=0, d_out=8'h55.
5. Glitch and rx_en gating:
   - In IDLE with data=0, ps2_clk low for 2 cycles -> busy stays 0.
   - rx_en=0 during a full frame -> no rx_done.
   - rx_en deasserted after the start bit -> frame still completes.
6. Timeout (PS2_RX_TIMEOUT_EN defined): start bit + 3 data bits, then clock held high -> rx_timeout pulse about 5000 cycles after the last strobe; busy=0, d_out unchanged. Following 0xAA frame is received correctly.

Source files
------------

// File: rtl/recibirps2.sv
// recibirps2 -- PS/2 device-to-host receiver.
//
// Takes the open-collector PS/2 clock and data lines and turns them into
// bytes for the keyboard scan-code logic. A frame is 11 bits: a start bit
// (0), 8 data bits sent LSB first, an odd parity bit and a stop bit (1).
// The line's clock is synchronized and then debounced before its falling
// edges are used. Data is sampled on each falling edge.
//
// Optional feature (compile-time macro PS2_RX_TIMEOUT_EN):
//   When it is defined, a watchdog aborts a frame that stalls mid-way.
//   When it is not defined, no watchdog exists, rx_timeout is tied to 0,
//   and a truncated frame waits for further clock edges.
//
// Parameters:
//   SYNC_STAGES  flip-flop stages on each of ps2_clk and ps2_data (>= 2)
//   FILTER_LEN   consecutive equal samples needed before clk_f changes
//   TIMEOUT_CYC  CLKOUT cycles without a falling edge before a frame is
//                aborted (used only with PS2_RX_TIMEOUT_EN)
//
// Ports:
//   CLKOUT      system clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   ps2_clk     raw PS/2 clock line (asynchronous)
//   ps2_data    raw PS/2 data line (asynchronous)
//   rx_en       1 = accept new frames (gates start-bit detection only)
//   d_out       last received byte
//   rx_done     one-cycle pulse when a frame completes
//   parity_err  parity of the last frame was bad (held until next rx_done)
//   frame_err   stop bit of the last frame was 0 (held until next rx_done)
//   busy        a frame is in progress
//   rx_timeout  one-cycle pulse when the watchdog aborts a frame

module recibirps2 #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       CLKOUT,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] d_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       rx_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FCW = $clog2(FILTER_LEN) + 1;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic [FCW-1:0] filt_cnt;
  logic           clk_f;
  logic           strobe;

  logic [7:0] shift_reg;
  logic [3:0] bit_cnt;
  logic       parity_bit;
  logic       frame_end;
  logic       timeout_hit;

  // Both lines idle high, so the synchronizers reset to 1. This ensures
  // that a reset is never seen as a falling clock edge.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // clk_f follows clk_s only after FILTER_LEN consecutive samples that
  // differ from clk_f. Any shorter excursion resets the run count.
  // The strobe is raised on the same edge where clk_f falls, so it is high
  // for exactly the one cycle that follows.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      clk_f    <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s != clk_f) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          clk_f    <= clk_s;
          filt_cnt <= '0;
          strobe   <= clk_f;
        end else begin
          filt_cnt <= filt_cnt + FCW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The FSM moves only on a strobe. The watchdog abort is the one
  // exception, and it can never coincide with a strobe.
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    if (timeout_hit) begin
      state_next = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          if (!data_s && rx_en) begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (bit_cnt == 4'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Data bits arrive LSB first. Shifting right with the new bit entering
  // at the MSB leaves the byte in natural order after 8 bits. The result
  // and the error flags are published at the stop-bit strobe, even when
  // the frame is bad.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      d_out      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= frame_end;
      if (strobe) begin
        case (state)
          IDLE: begin
            if (!data_s && rx_en) begin
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
          end
          PARITY: begin
            parity_bit <= data_s;
          end
          STOP: begin
            d_out      <= shift_reg;
            parity_err <= ~(^{shift_reg, parity_bit});
            frame_err  <= ~data_s;
          end
          default: begin
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC);

  logic [TCW-1:0] to_cnt;

  // The watchdog measures the gap since the last falling edge. It restarts
  // on every strobe and stays cleared while IDLE. Reaching the limit
  // abandons the frame without touching d_out or the error flags.
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= timeout_hit;
      if (state == IDLE || strobe || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TCW'(1);
      end
    end
  end

  assign timeout_hit = (state != IDLE) && !strobe &&
                       (to_cnt == TCW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
  assign rx_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_recibirps2.sv
// tb_recibirps2 -- self-checking bench for the recibirps2 PS/2 receiver.
//
// The bench drives whole PS/2 frames from a task. As each frame is sent,
// it predicts the outcome from the frame rules: the byte, the odd-parity
// verdict and the stop-bit verdict. It also predicts the cycle in which
// rx_done should pulse. A single monitor process compares rx_done, d_out
// and both error flags against those predictions on every cycle. Literal
// checks after the directed frames pin the prediction to known values.
`timescale 1ns/100ps

module tb_recibirps2;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TOUT = 5000;
  localparam int LAT  = SYNC + FILT + 1;

  logic       CLKOUT = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] d_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       rx_timeout;

  recibirps2 #(
    .SYNC_STAGES(SYNC),
    .FILTER_LEN(FILT),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .CLKOUT(CLKOUT),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .rx_en(rx_en),
    .d_out(d_out),
    .rx_done(rx_done),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy),
    .rx_timeout(rx_timeout)
  );

  always #1 CLKOUT = ~CLKOUT;

  int unsigned cycle = 0;
  always @(posedge CLKOUT) cycle++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  b;
    logic        pe;
    logic        fe;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  m_byte = 8'h00;
  logic        m_pe = 1'b0;
  logic        m_fe = 1'b0;
  int unsigned last_fall = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  // Sends the first nbits of a frame. Each bit's data value is placed in
  // the middle of the high phase. The line then holds low for 40 cycles
  // and high for 40 cycles. A complete frame that rx_en admitted at its
  // start bit queues its predicted result.
  task automatic applyStimulus(input logic [7:0] b, input logic par,
                               input logic stp, input int nbits,
                               input bit drop_en);
    logic [10:0] frame;
    bit          accepted;
    frame    = {stp, par, b, 1'b0};
    accepted = rx_en;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (20) @(negedge CLKOUT);
      ps2_clk   = 1'b0;
      last_fall = cycle;
      if (i == 10 && accepted) begin
        evq.push_back('{cycle + LAT, b,
                        ($countones({b, par}) % 2) == 0, stp == 1'b0});
      end
      repeat (40) @(negedge CLKOUT);
      ps2_clk = 1'b1;
      if (i == 0 && drop_en) rx_en = 1'b0;
      if (i == 3 && accepted) checkOutput("busy_mid", busy, 1);
      repeat (20) @(negedge CLKOUT);
    end
    ps2_data = 1'b1;
  endtask

  // Per-cycle comparison against the behavioural prediction.
  always begin
    @(posedge CLKOUT);
    #0.5;
    if (!rst_n) begin
      m_byte = 8'h00;
      m_pe   = 1'b0;
      m_fe   = 1'b0;
      evq.delete();
      checkOutput("reset_state",
                  {d_out, rx_done, parity_err, frame_err, busy, rx_timeout}, 0);
    end else begin
      if (evq.size() > 0 && evq[0].cyc == cycle) begin
        checkOutput("rx_done_pulse", rx_done, 1);
        m_byte = evq[0].b;
        m_pe   = evq[0].pe;
        m_fe   = evq[0].fe;
        void'(evq.pop_front());
      end else begin
        checkOutput("rx_done_quiet", rx_done, 0);
      end
      checkOutput("d_out", d_out, m_byte);
      checkOutput("parity_err", parity_err, m_pe);
      checkOutput("frame_err", frame_err, m_fe);
    end
  end

  initial begin
    int          hits;
    int unsigned first;
    logic [7:0]  rb;
    logic        rp;
    logic        rs;

    // Reset sequence, then a clean 0x1C frame.
    repeat (4) @(negedge CLKOUT);
    rst_n = 1'b1;
    repeat (10) @(negedge CLKOUT);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 0);
    checkOutput("t1_dout", d_out, 8'h1C);
    checkOutput("t1_perr", parity_err, 0);
    checkOutput("t1_ferr", frame_err, 0);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_model", m_byte, 8'h1C);

    // Back-to-back frames.
    applyStimulus(8'hF0, 1'b1, 1'b1, 11, 0);
    checkOutput("t2_dout_f0", d_out, 8'hF0);
    applyStimulus(8'hAA, 1'b1, 1'b1, 11, 0);
    checkOutput("t2_dout_aa", d_out, 8'hAA);
    checkOutput("t2_perr", parity_err, 0);

    // Bad parity, then a good frame clears the flag.
    applyStimulus(8'h1C, 1'b1, 1'b1, 11, 0);
    checkOutput("t3_perr_set", parity_err, 1);
    checkOutput("t3_dout", d_out, 8'h1C);
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 0);
    checkOutput("t3_perr_clr", parity_err, 0);

    // Stop bit low.
    applyStimulus(8'h55, 1'b1, 1'b0, 11, 0);
    checkOutput("t4_ferr", frame_err, 1);
    checkOutput("t4_perr", parity_err, 0);
    checkOutput("t4_dout", d_out, 8'h55);

    // Two-cycle clock glitch while data is low.
    ps2_data = 1'b0;
    repeat (20) @(negedge CLKOUT);
    ps2_clk = 1'b0;
    repeat (2) @(negedge CLKOUT);
    ps2_clk = 1'b1;
    repeat (10) @(negedge CLKOUT);
    checkOutput("t5_glitch_busy", busy, 0);
    ps2_data = 1'b1;
    repeat (20) @(negedge CLKOUT);

    // A frame sent with rx_en low is ignored.
    rx_en = 1'b0;
    applyStimulus(8'h3C, 1'b1, 1'b1, 11, 0);
    rx_en = 1'b1;
    checkOutput("t5_gated_dout", d_out, 8'h55);

    // rx_en dropping after the start bit does not stop the frame.
    applyStimulus(8'hA5, 1'b1, 1'b1, 11, 1);
    rx_en = 1'b1;
    checkOutput("t5_drop_dout", d_out, 8'hA5);

    // Reset mid-frame.
    applyStimulus(8'h77, 1'b0, 1'b1, 5, 0);
    rst_n = 1'b0;
    repeat (4) @(negedge CLKOUT);
    rst_n = 1'b1;
    repeat (10) @(negedge CLKOUT);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_dout", d_out, 8'h00);

    // Randomized frames.
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom);
      rp = ~(^rb);
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      rs = ($urandom_range(0, 9) != 0);
      rx_en = ($urandom_range(0, 7) != 0);
      applyStimulus(rb, rp, rs, 11, 0);
      rx_en = 1'b1;
    end

    // Truncated frame: start bit plus 3 data bits, then the clock stays high.
    applyStimulus(8'hB6, 1'b1, 1'b1, 4, 0);
    hits  = 0;
    first = 0;
    for (int k = 0; k < 5300; k++) begin
      @(negedge CLKOUT);
      if (rx_timeout) begin
        if (hits == 0) first = cycle;
        hits++;
      end
    end
`ifdef PS2_RX_TIMEOUT_EN
    checkOutput("timeout_pulses", hits, 1);
    checkOutput("timeout_window",
                (first >= last_fall + TOUT - 5) && (first <= last_fall + TOUT + 20), 1);
    checkOutput("timeout_busy", busy, 0);
`else
    checkOutput("no_timeout_pulses", hits, 0);
    checkOutput("no_timeout_busy", busy, 1);
    rst_n = 1'b0;
    repeat (4) @(negedge CLKOUT);
    rst_n = 1'b1;
    repeat (10) @(negedge CLKOUT);
`endif
    applyStimulus(8'hAA, 1'b1, 1'b1, 11, 0);
    checkOutput("t6_dout", d_out, 8'hAA);
    checkOutput("t6_perr", parity_err, 0);
    checkOutput("t6_ferr", frame_err, 0);
    repeat (10) @(negedge CLKOUT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
